// File: rtl/ddr_arb_pkg.sv
// Shared types and helpers for the DDR write arbiter.
// No logic of its own; imported by the arbiter top level.
// Beat size is fixed at 64 bytes to match the 512-bit DDR data path.
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam int BYTES_PER_BEAT = 64;
    localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
    localparam int LEN_MAX_WIDTH  = 64;

    // Number of data beats needed for a byte length, rounded up. The extra
    // top bit keeps the +63 from wrapping on the largest lengths.
    function automatic logic [LEN_MAX_WIDTH:0] beats_of(input logic [LEN_MAX_WIDTH-1:0] len);
        return ({1'b0, len} + (LEN_MAX_WIDTH+1)'(BYTES_PER_BEAT - 1)) >> BEAT_SHIFT;
    endfunction

endpackage

// File: rtl/ddr_write_arbiter_rr.sv
// Round-robin priority picker: first set request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
module rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_WIDTH-1:0] idx
);

    logic [IDX_WIDTH-1:0] cand;

    // Walk offsets from farthest to nearest so the closest request to ptr
    // is the one left standing when the loop ends.
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand = IDX_WIDTH'((int'(ptr) + i) % NUM_PORTS);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/ddr_write_arbiter.sv
// Shares one DDR command + data path among NUM_PORTS writers, round-robin, packet-atomic.
// Latency: grant to m_cmd_valid 1 cycle; data beats pass through with zero latency.
// Backpressure: m_cmd_ready/m_data_ready routed straight to the granted port's ready.
module ddr_write_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              s_cmd_valid,
    output logic [NUM_PORTS-1:0]              s_cmd_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   s_cmd_addr,
    input  logic [NUM_PORTS*LEN_WIDTH-1:0]    s_cmd_len,
    input  logic [NUM_PORTS-1:0]              s_data_valid,
    output logic [NUM_PORTS-1:0]              s_data_ready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_data,
    input  logic [NUM_PORTS-1:0]              s_data_last,
    output logic                              m_cmd_valid,
    input  logic                              m_cmd_ready,
    output logic [ADDR_WIDTH-1:0]             m_cmd_addr,
    output logic [LEN_WIDTH-1:0]              m_cmd_len,
    output logic                              m_data_valid,
    input  logic                              m_data_ready,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic [DATA_WIDTH/8-1:0]           m_data_keep,
    output logic                              m_data_last,
    output logic [$clog2(NUM_PORTS)-1:0]      grant_idx,
    output logic                              busy,
    output logic                              len_error,
    output logic [31:0]                       pkt_count
);

    localparam int IW = $clog2(NUM_PORTS);

    arb_state_t           state_q, state_d;
    logic [NUM_PORTS-1:0] arb_grant;
    logic [IW-1:0]        arb_idx;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        ptr_after;
    logic                 req_any;
    logic                 cmd_hs, dat_hs, dat_last, len_zero, pkt_done;
    logic [LEN_WIDTH:0]   beats_exp, beat_cnt, beat_nxt;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_WIDTH (IW)
    ) u_rr (
        .req   (s_cmd_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign req_any   = |arb_grant;
    assign cmd_hs    = (state_q == ST_CMD) && m_cmd_ready;
    assign dat_hs    = (state_q == ST_DATA) && s_data_valid[grant_idx] && m_data_ready;
    assign dat_last  = s_data_last[grant_idx];
    assign len_zero  = (m_cmd_len == '0);
    assign pkt_done  = (cmd_hs && len_zero) || (dat_hs && dat_last);
    assign beat_nxt  = beat_cnt + (LEN_WIDTH+1)'(1);
    assign ptr_after = (grant_idx == IW'(NUM_PORTS - 1)) ? '0 : grant_idx + IW'(1);
    assign m_data_keep = '1;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: a packet owns the path from command through last beat
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_any) state_d = ST_CMD;
            ST_CMD:  if (cmd_hs)  state_d = len_zero ? ST_IDLE : ST_DATA;
            ST_DATA: if (dat_hs && dat_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: ready steering and data forwarding from the owner only
    always_comb begin
        s_cmd_ready  = '0;
        s_data_ready = '0;
        m_data_valid = 1'b0;
        m_data_last  = 1'b0;
        m_data       = '0;
        if (state_q == ST_CMD) begin
            s_cmd_ready[grant_idx] = m_cmd_ready;
        end
        if (state_q == ST_DATA) begin
            s_data_ready[grant_idx] = m_data_ready;
            m_data_valid = s_data_valid[grant_idx];
            m_data_last  = s_data_last[grant_idx];
            m_data       = s_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Grant capture and registered downstream command
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_idx   <= '0;
            busy        <= 1'b0;
            m_cmd_valid <= 1'b0;
            m_cmd_addr  <= '0;
            m_cmd_len   <= '0;
        end else begin
            busy <= (state_d != ST_IDLE);
            if (state_q == ST_IDLE && req_any) begin
                grant_idx   <= arb_idx;
                m_cmd_valid <= 1'b1;
                m_cmd_addr  <= s_cmd_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                m_cmd_len   <= s_cmd_len[int'(arb_idx)*LEN_WIDTH +: LEN_WIDTH];
            end else if (cmd_hs) begin
                m_cmd_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer and completed-packet counter advance together
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            pkt_count <= '0;
        end else if (pkt_done) begin
            rr_ptr    <= ptr_after;
            pkt_count <= pkt_count + 32'd1;
        end
    end

    // Beat checker: compare accepted beats against the commanded length
    always_ff @(posedge clk) begin
        if (rst) begin
            beats_exp <= '0;
            beat_cnt  <= '0;
            len_error <= 1'b0;
        end else if (cmd_hs) begin
            beats_exp <= (LEN_WIDTH+1)'(beats_of(LEN_MAX_WIDTH'(m_cmd_len)));
            beat_cnt  <= '0;
        end else if (dat_hs) begin
            beat_cnt <= beat_nxt;
            // Short packets are caught at last; long ones at the first excess beat.
            if (dat_last ? (beat_nxt != beats_exp) : (beat_nxt > beats_exp)) begin
                len_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_write_arbiter.sv
// Directed bench for ddr_write_arbiter: reset, round-robin order, single packet,
// zero length, backpressure, mid-packet reset and length checking.
module tb_ddr_write_arbiter;

    localparam int NP = 4;
    localparam int DW = 512;
    localparam int AW = 64;
    localparam int LW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     s_cmd_valid, s_cmd_ready;
    logic [NP*AW-1:0]  s_cmd_addr;
    logic [NP*LW-1:0]  s_cmd_len;
    logic [NP-1:0]     s_data_valid, s_data_ready, s_data_last;
    logic [NP*DW-1:0]  s_data;
    logic              m_cmd_valid, m_cmd_ready;
    logic [AW-1:0]     m_cmd_addr;
    logic [LW-1:0]     m_cmd_len;
    logic              m_data_valid, m_data_ready, m_data_last;
    logic [DW-1:0]     m_data;
    logic [DW/8-1:0]   m_data_keep;
    logic [1:0]        grant_idx;
    logic              busy, len_error;
    logic [31:0]       pkt_count;

    int vectors     = 0;
    int miscompares = 0;
    int acc_cnt     = 0;
    int acc0;
    int order[6];
    int p;

    ddr_write_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .s_cmd_addr(s_cmd_addr), .s_cmd_len(s_cmd_len),
        .s_data_valid(s_data_valid), .s_data_ready(s_data_ready),
        .s_data(s_data), .s_data_last(s_data_last),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_cmd_addr(m_cmd_addr), .m_cmd_len(m_cmd_len),
        .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
        .m_data(m_data), .m_data_keep(m_data_keep), .m_data_last(m_data_last),
        .grant_idx(grant_idx), .busy(busy), .len_error(len_error), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    // downstream beat counter
    always @(posedge clk) if (m_data_valid && m_data_ready) acc_cnt <= acc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] pat(input int port, input int beat);
        logic [63:0] v;
        v = {32'(port) ^ 32'h5A00_0000, 32'(beat) ^ 32'hC0DE_0000};
        return {8{v}};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int port, input logic [AW-1:0] a, input logic [LW-1:0] l);
        s_cmd_addr[port*AW +: AW] = a;
        s_cmd_len[port*LW +: LW]  = l;
        s_cmd_valid[port]         = 1'b1;
    endtask

    task automatic set_dat(input int port, input int beat, input logic last);
        s_data[port*DW +: DW] = pat(port, beat);
        s_data_last[port]     = last;
        s_data_valid[port]    = 1'b1;
    endtask

    // One whole packet from an idle arbiter; len_error must read 1 once beat
    // index err_after has been accepted, 0 before that.
    task automatic run_pkt(input int port, input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input int nb, input int err_after, input string tag);
        int a0;
        set_cmd(port, a, l);
        @(negedge clk);
        chk({tag, " grant"}, grant_idx, port);
        chk({tag, " cmd_valid"}, m_cmd_valid, 1);
        chk({tag, " cmd_addr"}, m_cmd_addr, a);
        chk({tag, " cmd_len"}, m_cmd_len, l);
        chk({tag, " cmd_ready"}, s_cmd_ready, 1 << port);
        chk({tag, " busy_cmd"}, busy, 1);
        @(negedge clk);
        s_cmd_valid[port] = 1'b0;
        a0 = acc_cnt;
        for (int b = 0; b < nb; b++) begin
            set_dat(port, b, b == nb - 1);
            #1;
            chk({tag, " data_valid"}, m_data_valid, 1);
            chk({tag, " data"}, m_data, pat(port, b));
            chk({tag, " data_last"}, m_data_last, (b == nb - 1) ? 1 : 0);
            chk({tag, " data_ready"}, s_data_ready, 1 << port);
            @(negedge clk);
            chk({tag, " len_error"}, len_error, (b >= err_after) ? 1 : 0);
        end
        s_data_valid[port] = 1'b0;
        s_data_last[port]  = 1'b0;
        chk({tag, " beats"}, acc_cnt - a0, nb);
        chk({tag, " busy_end"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        s_cmd_valid = '0; s_cmd_addr = '0; s_cmd_len = '0;
        s_data_valid = '0; s_data = '0; s_data_last = '0;
        m_cmd_ready = 1'b1; m_data_ready = 1'b1;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst busy", busy, 0);
        chk("rst grant", grant_idx, 0);
        chk("rst pkt", pkt_count, 0);
        chk("rst len_error", len_error, 0);
        chk("rst cmd_valid", m_cmd_valid, 0);
        chk("rst data_valid", m_data_valid, 0);
        chk("rst keep", m_data_keep, {(DW/8){1'b1}});
        rst = 1'b0;

        // round-robin among ports 0, 2, 3 requesting continuously, 1 beat each
        order = '{0, 2, 3, 0, 2, 3};
        for (int q = 0; q < NP; q++) begin
            if (q != 1) begin
                set_cmd(q, 64'(256 * (q + 1)), 64);
                set_dat(q, 0, 1'b1);
            end
        end
        for (int k = 0; k < 6; k++) begin
            p = order[k];
            @(negedge clk);
            chk("rr grant", grant_idx, p);
            chk("rr cmd_valid", m_cmd_valid, 1);
            chk("rr cmd_addr", m_cmd_addr, 64'(256 * (p + 1)));
            chk("rr busy", busy, 1);
            @(negedge clk);
            chk("rr data", m_data, pat(p, 0));
            chk("rr data_ready", s_data_ready, 1 << p);
            @(negedge clk);
            chk("rr idle cmd_valid", m_cmd_valid, 0);
            chk("rr idle busy", busy, 0);
            if (k == 5) begin
                s_cmd_valid = '0; s_data_valid = '0; s_data_last = '0;
            end
        end
        chk("rr pkt", pkt_count, 6);

        // single port 1 packet, 256 bytes = 4 beats
        run_pkt(1, 64'h1000, 256, 4, 4, "t1");
        chk("t1 pkt", pkt_count, 7);

        // ports 0 and 2 zero-length: pointer now at 2 so port 2 goes first
        set_cmd(0, 64'h2000, 0);
        set_cmd(2, 64'h2200, 0);
        @(negedge clk);
        chk("zl first grant", grant_idx, 2);
        chk("zl first busy", busy, 1);
        @(negedge clk);
        s_cmd_valid[2] = 1'b0;
        chk("zl first idle", busy, 0);
        chk("zl first data_valid", m_data_valid, 0);
        chk("zl first pkt", pkt_count, 8);
        @(negedge clk);
        chk("zl second grant", grant_idx, 0);
        chk("zl second busy", busy, 1);
        chk("zl second len", m_cmd_len, 0);
        @(negedge clk);
        s_cmd_valid[0] = 1'b0;
        chk("zl second idle", busy, 0);
        chk("zl second pkt", pkt_count, 9);

        // backpressure: m_data_ready toggles on a 3-beat packet from port 2
        set_cmd(2, 64'h3000, 192);
        @(negedge clk);
        chk("bp grant", grant_idx, 2);
        @(negedge clk);
        s_cmd_valid[2] = 1'b0;
        acc0 = acc_cnt;
        for (int c = 0; c < 6; c++) begin
            m_data_ready = 1'(c % 2);
            set_dat(2, c / 2, (c / 2) == 2);
            #1;
            chk("bp data_ready", s_data_ready, (c % 2 == 1) ? 4 : 0);
            chk("bp data", m_data, pat(2, c / 2));
            chk("bp data_valid", m_data_valid, 1);
            @(negedge clk);
        end
        s_data_valid[2] = 1'b0; s_data_last[2] = 1'b0;
        m_data_ready = 1'b1;
        chk("bp beats", acc_cnt - acc0, 3);
        chk("bp busy", busy, 0);
        chk("bp pkt", pkt_count, 10);
        chk("bp len_error", len_error, 0);

        // reset after beat 2 of 4 of a port 1 packet
        set_cmd(1, 64'h4000, 256);
        @(negedge clk);
        chk("mr grant", grant_idx, 1);
        @(negedge clk);
        s_cmd_valid[1] = 1'b0;
        for (int b = 0; b < 2; b++) begin
            set_dat(1, b, 1'b0);
            @(negedge clk);
        end
        set_dat(1, 2, 1'b0);
        rst = 1'b1;
        set_cmd(3, 64'h5000, 64);
        @(negedge clk);
        chk("mr data_valid", m_data_valid, 0);
        chk("mr data_ready", s_data_ready, 0);
        chk("mr cmd_valid", m_cmd_valid, 0);
        chk("mr busy", busy, 0);
        chk("mr grant0", grant_idx, 0);
        chk("mr pkt", pkt_count, 0);
        chk("mr len_error", len_error, 0);
        rst = 1'b0;
        s_data_valid[1] = 1'b0;
        run_pkt(3, 64'h5000, 64, 1, 1, "mr fresh");
        chk("mr fresh pkt", pkt_count, 1);

        // overrun: 64 bytes (1 beat) sent as 3 beats, flagged at beat index 1
        run_pkt(0, 64'h6000, 64, 3, 1, "ovr");
        chk("ovr pkt", pkt_count, 2);
        // underrun: 128 bytes (2 beats) with last on beat 1; flag stays set
        run_pkt(1, 64'h7000, 128, 1, 0, "und");
        chk("und pkt", pkt_count, 3);
        chk("und len_error", len_error, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
